// File: rtl/multicycle_controller.sv
// rtl/multicycle_controller.sv - multi-cycle RISC-V control FSM with shared memory port handshake.
// Optional performance counters are built when CTRL_PERF_CNT_EN is defined.
module multicycle_controller #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [6:0]       op,
  input  logic [2:0]       func3,
  input  logic [6:0]       func7,
  input  logic             alu_zero,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_write,
  output logic             adr_src,
  output logic             ir_write,
  output logic             pc_write,
  output logic             reg_write,
  output logic [1:0]       result_src,
  output logic [1:0]       alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [2:0]       imm_src,
  output logic [2:0]       alu_ctrl,
  output logic             illegal,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instret_cnt
);

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
    S_EXECR, S_EXECI, S_ALUWB, S_BEQ, S_JAL, S_ILLEGAL
  } state_t;

  state_t     state;
  state_t     next_state;
  logic [1:0] alu_op;
  logic       in_fetch;
  logic       in_beq;
  logic       pc_force;
  logic       unused_func7;

  assign unused_func7 = ^{func7[6], func7[4:0]};

  always_comb begin
    next_state = state;
    case (state)
      S_FETCH:    if (mem_ready) next_state = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW: next_state = S_MEMADR;
          OP_R:         next_state = S_EXECR;
          OP_I:         next_state = S_EXECI;
          OP_BEQ:       next_state = S_BEQ;
          OP_JAL:       next_state = S_JAL;
          default:      next_state = S_ILLEGAL;
        endcase
      end
      S_MEMADR:   next_state = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  if (mem_ready) next_state = S_MEMWB;
      S_MEMWB:    next_state = S_FETCH;
      S_MEMWRITE: if (mem_ready) next_state = S_FETCH;
      S_EXECR:    next_state = S_ALUWB;
      S_EXECI:    next_state = S_ALUWB;
      S_ALUWB:    next_state = S_FETCH;
      S_BEQ:      next_state = S_FETCH;
      S_JAL:      next_state = S_ALUWB;
      S_ILLEGAL:  next_state = S_ILLEGAL;
      default:    next_state = S_FETCH;
    endcase
  end

  // Outputs are registered from the next state, so they always reflect the current state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_FETCH;
      mem_req    <= 1'b1;
      mem_write  <= 1'b0;
      adr_src    <= 1'b0;
      reg_write  <= 1'b0;
      result_src <= 2'b10;
      alu_src_a  <= 2'b00;
      alu_src_b  <= 2'b10;
      alu_op     <= 2'b00;
      in_fetch   <= 1'b1;
      in_beq     <= 1'b0;
      pc_force   <= 1'b0;
      illegal    <= 1'b0;
    end else begin
      state      <= next_state;
      mem_req    <= 1'b0;
      mem_write  <= 1'b0;
      adr_src    <= 1'b0;
      reg_write  <= 1'b0;
      result_src <= 2'b00;
      alu_src_a  <= 2'b00;
      alu_src_b  <= 2'b00;
      alu_op     <= 2'b00;
      in_fetch   <= 1'b0;
      in_beq     <= 1'b0;
      pc_force   <= 1'b0;
      illegal    <= illegal | (next_state == S_ILLEGAL);
      case (next_state)
        S_FETCH: begin
          mem_req    <= 1'b1;
          result_src <= 2'b10;
          alu_src_b  <= 2'b10;
          in_fetch   <= 1'b1;
        end
        S_DECODE: begin
          alu_src_a <= 2'b01;
          alu_src_b <= 2'b01;
        end
        S_MEMADR, S_EXECI: begin
          alu_src_a <= 2'b10;
          alu_src_b <= 2'b01;
          alu_op    <= (next_state == S_EXECI) ? 2'b10 : 2'b00;
        end
        S_MEMREAD: begin
          mem_req <= 1'b1;
          adr_src <= 1'b1;
        end
        S_MEMWB: begin
          result_src <= 2'b01;
          reg_write  <= 1'b1;
        end
        S_MEMWRITE: begin
          mem_req   <= 1'b1;
          mem_write <= 1'b1;
          adr_src   <= 1'b1;
        end
        S_EXECR: begin
          alu_src_a <= 2'b10;
          alu_op    <= 2'b10;
        end
        S_ALUWB: reg_write <= 1'b1;
        S_BEQ: begin
          alu_src_a <= 2'b10;
          alu_op    <= 2'b01;
          in_beq    <= 1'b1;
        end
        S_JAL: begin
          alu_src_a <= 2'b01;
          alu_src_b <= 2'b10;
          pc_force  <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign ir_write = in_fetch & mem_ready;
  assign pc_write = pc_force | (in_fetch & mem_ready) | (in_beq & alu_zero);

  always_comb begin
    alu_ctrl = 3'b000;
    case (alu_op)
      2'b01: alu_ctrl = 3'b001;
      2'b10: begin
        case (func3)
          3'b000:  alu_ctrl = (op[5] & func7[5]) ? 3'b001 : 3'b000;
          3'b010:  alu_ctrl = 3'b101;
          3'b110:  alu_ctrl = 3'b011;
          3'b111:  alu_ctrl = 3'b010;
          default: alu_ctrl = 3'b111;
        endcase
      end
      default: alu_ctrl = 3'b000;
    endcase
  end

  always_comb begin
    imm_src = 3'b000;
    case (op)
      OP_SW:   imm_src = 3'b001;
      OP_BEQ:  imm_src = 3'b010;
      OP_JAL:  imm_src = 3'b011;
      default: imm_src = 3'b000;
    endcase
  end

`ifdef CTRL_PERF_CNT_EN
  logic [CNT_W-1:0] cycle_q;
  logic [CNT_W-1:0] instret_q;

  // A retirement is any return to FETCH from another state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cycle_q   <= '0;
      instret_q <= '0;
    end else begin
      cycle_q <= cycle_q + CNT_W'(1);
      if (state != S_FETCH && next_state == S_FETCH)
        instret_q <= instret_q + CNT_W'(1);
    end
  end

  assign cycle_cnt   = cycle_q;
  assign instret_cnt = instret_q;
`else
  assign cycle_cnt   = '0;
  assign instret_cnt = '0;
`endif

endmodule

// File: tb/tb_multicycle_controller.sv
// tb/tb_multicycle_controller.sv - directed scripts checked against a per-instruction phase model.
module tb_multicycle_controller;

  localparam int CW = 4;
`ifdef CTRL_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_BAD = 7'b1111111;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [6:0] op = OP_LW;
  logic [2:0] func3 = 3'b000;
  logic [6:0] func7 = 7'b0000000;
  logic alu_zero = 1'b0;
  logic mem_ready = 1'b0;
  logic mem_req, mem_write, adr_src, ir_write, pc_write, reg_write, illegal;
  logic [1:0] result_src, alu_src_a, alu_src_b;
  logic [2:0] imm_src, alu_ctrl;
  logic [CW-1:0] cycle_cnt, instret_cnt;

  multicycle_controller #(.CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .op(op), .func3(func3), .func7(func7),
    .alu_zero(alu_zero), .mem_ready(mem_ready), .mem_req(mem_req),
    .mem_write(mem_write), .adr_src(adr_src), .ir_write(ir_write),
    .pc_write(pc_write), .reg_write(reg_write), .result_src(result_src),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .imm_src(imm_src),
    .alu_ctrl(alu_ctrl), .illegal(illegal), .cycle_cnt(cycle_cnt),
    .instret_cnt(instret_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic        zero;
    logic        mr;
    logic        last;
    logic [18:0] exp;
  } row_t;

  row_t q[$];
  row_t cur;
  bit   exp_valid = 1'b0;
  int   total = 0;
  int   bad = 0;
  logic [CW-1:0] m_cyc = '0;
  logic [CW-1:0] m_inst = '0;
  logic [6:0] b_op;
  logic [2:0] b_f3;
  logic [6:0] b_f7;
  logic       b_zero;

  function automatic logic [18:0] pk(input logic rq, input logic mw, input logic ad,
      input logic ir, input logic pc, input logic rw, input logic [1:0] rs,
      input logic [1:0] a, input logic [1:0] b, input logic [2:0] imm,
      input logic [2:0] alu, input logic ill);
    return {rq, mw, ad, ir, pc, rw, rs, a, b, imm, alu, ill};
  endfunction

  function automatic logic [2:0] m_imm(input logic [6:0] o);
    if (o == OP_SW) return 3'b001;
    if (o == OP_BEQ) return 3'b010;
    if (o == OP_JAL) return 3'b011;
    return 3'b000;
  endfunction

  function automatic logic [2:0] m_alu(input logic [1:0] aop, input logic [6:0] o,
      input logic [2:0] f3, input logic [6:0] f7);
    if (aop == 2'b01) return 3'b001;
    if (aop != 2'b10) return 3'b000;
    case (f3)
      3'b000:  return (o[5] && f7[5]) ? 3'b001 : 3'b000;
      3'b010:  return 3'b101;
      3'b110:  return 3'b011;
      3'b111:  return 3'b010;
      default: return 3'b111;
    endcase
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, want);
    end
  endtask

  task automatic push(input string nm, input logic mr, input logic last, input logic [18:0] e);
    row_t r;
    r.name = nm; r.op = b_op; r.f3 = b_f3; r.f7 = b_f7; r.zero = b_zero;
    r.mr = mr; r.last = last; r.exp = e;
    q.push_back(r);
  endtask

  // One instruction expands into its phase sequence; fw/mw are memory wait cycles.
  task automatic add_instr(input logic [6:0] o, input logic [2:0] f3, input logic [6:0] f7,
      input logic z, input int fw, input int mw);
    logic [2:0] im;
    b_op = o; b_f3 = f3; b_f7 = f7; b_zero = z;
    im = m_imm(o);
    for (int i = 0; i <= fw; i++) begin
      logic r;
      r = (i == fw);
      push("fetch", r, 1'b0, pk(1, 0, 0, r, r, 0, 2'b10, 2'b00, 2'b10, im, 3'b000, 0));
    end
    push("decode", 1'($urandom_range(0, 1)), 1'b0,
         pk(0, 0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, im, 3'b000, 0));
    case (o)
      OP_LW, OP_SW: begin
        push("memadr", 1'($urandom_range(0, 1)), 1'b0,
             pk(0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, im, 3'b000, 0));
        for (int i = 0; i <= mw; i++) begin
          if (o == OP_LW)
            push("memread", i == mw, 1'b0, pk(1, 0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, im, 3'b000, 0));
          else
            push("memwrite", i == mw, i == mw, pk(1, 1, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, im, 3'b000, 0));
        end
        if (o == OP_LW)
          push("memwb", 1'($urandom_range(0, 1)), 1'b1,
               pk(0, 0, 0, 0, 0, 1, 2'b01, 2'b00, 2'b00, im, 3'b000, 0));
      end
      OP_R, OP_I: begin
        push("exec", 1'($urandom_range(0, 1)), 1'b0,
             pk(0, 0, 0, 0, 0, 0, 2'b00, 2'b10, (o == OP_I) ? 2'b01 : 2'b00, im,
                m_alu(2'b10, o, f3, f7), 0));
        push("aluwb", 1'($urandom_range(0, 1)), 1'b1,
             pk(0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, im, 3'b000, 0));
      end
      OP_BEQ:
        push("beq", 1'($urandom_range(0, 1)), 1'b1,
             pk(0, 0, 0, 0, z, 0, 2'b00, 2'b10, 2'b00, im, m_alu(2'b01, o, f3, f7), 0));
      OP_JAL: begin
        push("jal", 1'($urandom_range(0, 1)), 1'b0,
             pk(0, 0, 0, 0, 1, 0, 2'b00, 2'b01, 2'b10, im, 3'b000, 0));
        push("aluwb", 1'($urandom_range(0, 1)), 1'b1,
             pk(0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, im, 3'b000, 0));
      end
      default:
        for (int i = 0; i < 10; i++)
          push("illegal", 1'($urandom_range(0, 1)), 1'b0,
               pk(0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, im, 3'b000, 1));
    endcase
  endtask

  task automatic play(input int n);
    int k;
    k = 0;
    while (q.size() > 0 && (n == 0 || k < n)) begin
      @(negedge clk);
      cur = q.pop_front();
      op = cur.op; func3 = cur.f3; func7 = cur.f7; alu_zero = cur.zero; mem_ready = cur.mr;
      exp_valid = 1'b1;
      k++;
    end
  endtask

  task automatic do_reset();
    exp_valid = 1'b0;
    mem_ready = 1'b0;
    rst = 1'b1;
    #1;
    chk("reset_rdy0", {13'd0, mem_req, mem_write, adr_src, ir_write, pc_write, reg_write,
        result_src, alu_src_a, alu_src_b, imm_src, alu_ctrl, illegal},
        {13'd0, pk(1, 0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b10, m_imm(op), 3'b000, 0)});
    mem_ready = 1'b1;
    #1;
    chk("reset_rdy1", {13'd0, mem_req, mem_write, adr_src, ir_write, pc_write, reg_write,
        result_src, alu_src_a, alu_src_b, imm_src, alu_ctrl, illegal},
        {13'd0, pk(1, 0, 0, 1, 1, 0, 2'b10, 2'b00, 2'b10, m_imm(op), 3'b000, 0)});
    mem_ready = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_cyc  <= '0;
      m_inst <= '0;
    end else begin
      m_cyc <= m_cyc + CW'(1);
      if (exp_valid && cur.last) m_inst <= m_inst + CW'(1);
    end
  end

  always @(negedge clk) begin
    #2;
    if (exp_valid) begin
      chk(cur.name, {13'd0, mem_req, mem_write, adr_src, ir_write, pc_write, reg_write,
          result_src, alu_src_a, alu_src_b, imm_src, alu_ctrl, illegal}, {13'd0, cur.exp});
      chk("counters", {24'd0, cycle_cnt, instret_cnt},
          {24'd0, PERF ? m_cyc : CW'(0), PERF ? m_inst : CW'(0)});
    end
  end

  initial begin
    #1;
    do_reset();

    chk("pin_rsub", {29'd0, m_alu(2'b10, OP_R, 3'b000, 7'b0100000)}, 32'd1);
    chk("pin_iadd", {29'd0, m_alu(2'b10, OP_I, 3'b000, 7'b0100000)}, 32'd0);
    chk("pin_swimm", {29'd0, m_imm(OP_SW)}, 32'd1);
    add_instr(OP_LW, 3'b010, 7'd0, 1'b0, 2, 1);
    chk("pin_lw_len", q.size(), 32'd8);
    play(0);

    add_instr(OP_SW, 3'b010, 7'd0, 1'b0, 0, 0);
    chk("pin_sw_len", q.size(), 32'd4);
    add_instr(OP_R, 3'b000, 7'b0100000, 1'b0, 0, 0);
    add_instr(OP_I, 3'b000, 7'b0100000, 1'b0, 0, 0);
    add_instr(OP_R, 3'b111, 7'd0, 1'b0, 0, 0);
    add_instr(OP_I, 3'b110, 7'd0, 1'b0, 0, 0);
    add_instr(OP_R, 3'b010, 7'd0, 1'b0, 0, 0);
    add_instr(OP_R, 3'b100, 7'd0, 1'b0, 0, 0);
    add_instr(OP_BEQ, 3'b000, 7'd0, 1'b1, 0, 0);
    add_instr(OP_BEQ, 3'b000, 7'd0, 1'b0, 0, 0);
    add_instr(OP_JAL, 3'b000, 7'd0, 1'b1, 0, 0);
    add_instr(OP_SW, 3'b010, 7'd0, 1'b0, 1, 2);
    add_instr(OP_LW, 3'b010, 7'd0, 1'b1, 0, 0);
    play(0);

    add_instr(OP_BAD, 3'b000, 7'd0, 1'b0, 0, 0);
    play(0);
    #3;
    do_reset();
    add_instr(OP_LW, 3'b010, 7'd0, 1'b0, 0, 0);
    play(0);

    // Reset lands while a store is waiting on memory.
    add_instr(OP_SW, 3'b010, 7'd0, 1'b0, 0, 2);
    play(4);
    #3;
    do_reset();
    q.delete();

    add_instr(OP_BEQ, 3'b000, 7'd0, 1'b0, 0, 0);
    add_instr(OP_R, 3'b110, 7'd0, 1'b0, 0, 0);
    add_instr(OP_SW, 3'b010, 7'd0, 1'b0, 0, 0);
    add_instr(OP_R, 3'b111, 7'd0, 1'b0, 4, 0);
    play(15);
    @(negedge clk);
    exp_valid = 1'b0;
    mem_ready = 1'b0;
    #3;
    chk("cycle_wrap", {28'd0, cycle_cnt}, 32'd0);
    chk("instret3", {28'd0, instret_cnt}, PERF ? 32'd3 : 32'd0);
    play(0);
    @(negedge clk);
    exp_valid = 1'b0;
    #3;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
